tcam_ctrl: RTL and testbench

TCAM_CTRL -- requirements
Module: tcam_ctrl

---
 rtl/tcam_pkg.sv | 29 ++
 rtl/tcam_rule_match.sv | 21 ++
 rtl/tcam_ctrl.sv | 136 +++++++++++++
 tb/tb_tcam_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared types and sizing for the TCAM controller: opcodes, FSM states,
// shadow rule layout.
package tcam_pkg;
  localparam int KEY_W   = 28;
  localparam int SLICE_W = 7;
  localparam int N_BLK   = 4;
  localparam int N_ENTRY = 64;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_WRITE  = 2'd1,
    OP_INVAL  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    SEARCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] value;
    logic [KEY_W-1:0] care;
  } rule_t;
endpackage

// File: rtl/tcam_rule_match.sv
// Ternary match of one shadow rule against a full key and against one
// 7-bit slice (selected by blk) of the rule.
module tcam_rule_match
  import tcam_pkg::*;
(
  input  logic               valid,
  input  logic [KEY_W-1:0]   value,
  input  logic [KEY_W-1:0]   care,
  input  logic [KEY_W-1:0]   key,
  input  logic [1:0]         blk,
  input  logic [SLICE_W-1:0] row,
  output logic               key_hit,
  output logic               slice_hit
);
  logic [SLICE_W-1:0] v_sl, c_sl;

  assign v_sl      = value[blk*SLICE_W +: SLICE_W];
  assign c_sl      = care[blk*SLICE_W +: SLICE_W];
  assign key_hit   = valid && (((key ^ value) & care) == '0);
  assign slice_hit = valid && (((row ^ v_sl) & c_sl) == '0);
endmodule

// File: rtl/tcam_ctrl.sv
// TCAM controller: keeps a shadow of 64 ternary rules, rewrites the macro
// array with a 512-cycle sweep on every rule change, and runs searches.
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int SEARCH_LAT = 1
) (
  input  logic             in_clk,
  input  logic             in_rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_entry,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [KEY_W-1:0] cmd_care,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [5:0]       rsp_pma,
  output logic             tcam_csb,
  output logic             tcam_web,
  output logic [3:0]       tcam_wmask,
  output logic [27:0]      tcam_addr,
  output logic [31:0]      tcam_wdata,
  input  logic [5:0]       tcam_pma
);
  localparam logic [1:0] LAST_WAIT = 2'(SEARCH_LAT - 1);

  state_e             state, state_nx;
  rule_t              shadow [N_ENTRY];
  logic [5:0]         entry_q;
  logic [8:0]         sweep_cnt;
  logic [1:0]         wait_cnt;
  logic [KEY_W-1:0]   key_q;
  logic [N_ENTRY-1:0] key_hit, slice_hit;
  logic [7:0]         sweep_byte;
  logic               accept;

  assign accept = cmd_valid && cmd_ready;

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_match
    tcam_rule_match u_match (
      .valid     (shadow[g].valid),
      .value     (shadow[g].value),
      .care      (shadow[g].care),
      .key       (cmd_key),
      .blk       (sweep_cnt[8:7]),
      .row       (sweep_cnt[6:0]),
      .key_hit   (key_hit[g]),
      .slice_hit (slice_hit[g])
    );
  end

  // One byte covers the 8 rules sharing the written rule's group, so the
  // neighbours' bits are regenerated from their own shadow entries.
  assign sweep_byte = slice_hit[{entry_q[5:3], 3'b000} +: 8];

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cmd_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    tcam_csb   = 1'b1;
    tcam_web   = 1'b1;
    tcam_wmask = '0;
    tcam_addr  = '0;
    tcam_wdata = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_SEARCH:          state_nx = SEARCH;
            OP_WRITE, OP_INVAL: state_nx = SWEEP;
            default:            state_nx = IDLE;
          endcase
        end
      end
      SWEEP: begin
        tcam_csb   = 1'b0;
        tcam_web   = 1'b0;
        tcam_addr  = {18'b0, sweep_cnt[8:7], entry_q[5], sweep_cnt[6:0]};
        tcam_wmask = 4'b0001 << entry_q[4:3];
        tcam_wdata = {4{sweep_byte}};
        if (sweep_cnt == 9'd511) state_nx = IDLE;
      end
      SEARCH: begin
        tcam_csb  = 1'b0;
        tcam_addr = key_q;
        state_nx  = WAIT;
      end
      WAIT:    if (wait_cnt == LAST_WAIT) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      for (int i = 0; i < N_ENTRY; i++) shadow[i] <= '0;
      entry_q   <= '0;
      sweep_cnt <= '0;
      wait_cnt  <= '0;
      key_q     <= '0;
      rsp_hit   <= 1'b0;
      rsp_pma   <= '0;
    end else begin
      if (accept) begin
        case (op_e'(cmd_op))
          OP_SEARCH: begin
            key_q   <= cmd_key;
            rsp_hit <= |key_hit;
          end
          OP_WRITE: begin
            shadow[cmd_entry] <= '{valid: 1'b1, value: cmd_key, care: cmd_care};
            entry_q           <= cmd_entry;
          end
          OP_INVAL: begin
            shadow[cmd_entry].valid <= 1'b0;
            entry_q                 <= cmd_entry;
          end
          default: ;
        endcase
      end
      if (state == SWEEP) sweep_cnt <= sweep_cnt + 9'd1;
      if (state == SEARCH) wait_cnt <= '0;
      else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
        if (wait_cnt == LAST_WAIT) rsp_pma <= tcam_pma;
      end
    end
  end
endmodule

// File: tb/tb_tcam_ctrl.sv
// Bench for tcam_ctrl: behavioural TCAM macro plus a rule-list reference
// model; random rule traffic, sweep content, search priority and reset.
module tb_tcam_ctrl;
  logic        in_clk = 1'b0, in_rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_entry = '0;
  logic [27:0] cmd_key = '0, cmd_care = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_hit;
  logic [5:0]  rsp_pma;
  logic        tcam_csb, tcam_web;
  logic [3:0]  tcam_wmask;
  logic [27:0] tcam_addr;
  logic [31:0] tcam_wdata;
  logic [5:0]  tcam_pma = '0;

  int checks = 0, errors = 0;
  int n_rd = 0, n_wr = 0;
  logic [31:0] mem [1024];
  bit          mv [64];
  logic [27:0] mk [64], mc [64];
  logic [7:0]  obs_byte [512];
  logic [3:0]  obs_mask [512];

  always #5 in_clk = ~in_clk;

  tcam_ctrl #(.SEARCH_LAT(1)) dut (
    .in_clk(in_clk), .in_rstn(in_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_entry(cmd_entry), .cmd_key(cmd_key), .cmd_care(cmd_care),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_pma(rsp_pma),
    .tcam_csb(tcam_csb), .tcam_web(tcam_web), .tcam_wmask(tcam_wmask),
    .tcam_addr(tcam_addr), .tcam_wdata(tcam_wdata), .tcam_pma(tcam_pma)
  );

  // Macro model: entry e lives at bit (e%32) of lane-interleaved words in
  // half e/32 of each block; lowest matching entry wins.
  function automatic logic [5:0] tcam_lookup(input logic [27:0] key);
    for (int e = 0; e < 64; e++) begin
      bit ok = 1;
      for (int b = 0; b < 4; b++) begin
        int a = b * 256 + (e / 32) * 128 + int'(key[b*7 +: 7]);
        int bi = ((e / 8) % 4) * 8 + e % 8;
        if (mem[a][bi] !== 1'b1) ok = 0;
      end
      if (ok) return 6'(e);
    end
    return 6'd0;
  endfunction

  always @(posedge in_clk) begin
    if (!tcam_csb && !tcam_web) begin
      n_wr++;
      for (int l = 0; l < 4; l++)
        if (tcam_wmask[l]) mem[tcam_addr[9:0]][l*8 +: 8] = tcam_wdata[l*8 +: 8];
    end
    if (!tcam_csb && tcam_web) begin
      n_rd++;
      tcam_pma <= tcam_lookup(tcam_addr);
    end else tcam_pma <= 6'($urandom);
  end

  function automatic int model_first(input logic [27:0] key);
    for (int e = 0; e < 64; e++)
      if (mv[e] && (((key ^ mk[e]) & mc[e]) == 28'd0)) return e;
    return -1;
  endfunction

  function automatic logic [7:0] exp_byte(input int ent, input int blk, input int row);
    logic [7:0] b = '0;
    for (int j = 0; j < 8; j++) begin
      int e = (ent / 8) * 8 + j;
      if (mv[e] && (((7'(row) ^ mk[e][blk*7 +: 7]) & mc[e][blk*7 +: 7]) == 7'd0)) b[j] = 1'b1;
    end
    return b;
  endfunction

  task automatic send(input logic [1:0] op, input logic [5:0] ent,
                      input logic [27:0] key, input logic [27:0] care);
    int n = 0;
    @(negedge in_clk);
    while (!cmd_ready && n < 1000) begin @(negedge in_clk); n++; end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_entry = ent; cmd_key = key; cmd_care = care;
    @(posedge in_clk);
    #1 cmd_valid = 1'b0;
    if (op == 2'd1) begin mv[ent] = 1; mk[ent] = key; mc[ent] = care; end
    if (op == 2'd2) mv[ent] = 0;
  endtask

  task automatic sweep(input logic [5:0] ent, input int abort_at);
    int bad = 0;
    for (int c = 0; c < 512; c++) begin
      logic [27:0] ea;
      logic [3:0]  em;
      logic [7:0]  eb;
      @(negedge in_clk);
      if (c == abort_at) return;
      ea = 28'((c / 128) * 256 + int'(ent[5]) * 128 + c % 128);
      em = 4'(1 << int'(ent[4:3]));
      eb = exp_byte(int'(ent), c / 128, c % 128);
      obs_byte[c] = tcam_wdata[7:0];
      obs_mask[c] = tcam_wmask;
      if (tcam_csb !== 1'b0 || tcam_web !== 1'b0 || tcam_addr !== ea ||
          tcam_wmask !== em || tcam_wdata !== {4{eb}}) begin
        if (bad == 0)
          $display("FAIL sweep_cycle %0d: got csb=%b web=%b addr=%h mask=%b data=%h want addr=%h mask=%b data=%h",
                   c, tcam_csb, tcam_web, tcam_addr, tcam_wmask, tcam_wdata, ea, em, {4{eb}});
        bad++;
      end
    end
    checks++; if (bad != 0) errors++;
    @(negedge in_clk);
    checks++;
    if (tcam_csb !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sweep_end: got csb=%b ready=%b want 1 1", tcam_csb, cmd_ready);
    end
  endtask

  task automatic search(input logic [27:0] key, input int hold, input bit chk_pma);
    int fe = model_first(key);
    int nr0 = n_rd, n = 0, bad = 0;
    logic [5:0] ep = (fe < 0) ? 6'd0 : 6'(fe);
    send(2'd0, 6'd0, key, 28'd0);
    do begin @(negedge in_clk); n++; end while (!rsp_valid && n < 20);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout: got %b want 1", rsp_valid); end
    checks++;
    if (rsp_hit !== (fe >= 0)) begin
      errors++; $display("FAIL rsp_hit key=%h: got %b want %b", key, rsp_hit, fe >= 0);
    end
    if (chk_pma) begin
      checks++;
      if (rsp_pma !== ep) begin
        errors++; $display("FAIL rsp_pma key=%h: got %0d want %0d", key, rsp_pma, ep);
      end
    end
    checks++;
    if (n_rd - nr0 != 1) begin errors++; $display("FAIL read_cycles: got %0d want 1", n_rd - nr0); end
    for (int h = 0; h < hold; h++) begin
      @(negedge in_clk);
      if (rsp_valid !== 1'b1 || rsp_hit !== (fe >= 0) || (chk_pma && rsp_pma !== ep)) bad++;
    end
    if (hold > 0) begin
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rsp_hold: got %0d unstable cycles want 0", bad); end
    end
    rsp_ready = 1'b1;
    @(posedge in_clk);
    #1 rsp_ready = 1'b0;
    @(negedge in_clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_release: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_pma !== 6'd0 ||
        tcam_csb !== 1'b1 || tcam_web !== 1'b1 || tcam_wmask !== 4'd0 ||
        tcam_addr !== 28'd0 || tcam_wdata !== 32'd0) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b hit=%b pma=%h csb=%b web=%b mask=%h addr=%h data=%h want 1 0 0 0 1 1 0 0 0",
               tag, cmd_ready, rsp_valid, rsp_hit, rsp_pma, tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge in_clk);
    check_reset_outputs("reset_state");
    in_rstn = 1'b1;
    @(negedge in_clk);
    check_reset_outputs("post_release");
  endtask

  task automatic test_search_empty();
    int nw0 = n_wr;
    search(28'h0000000, 0, 1);
    checks++;
    if (n_wr != nw0) begin errors++; $display("FAIL empty_search_writes: got %0d want 0", n_wr - nw0); end
  endtask

  task automatic test_write();
    int other = 0;
    send(2'd1, 6'd5, 28'h1234567, 28'hFFFFFFF);
    sweep(6'd5, -1);
    checks++;
    if (obs_byte[8'h67] !== 8'h20) begin
      errors++; $display("FAIL blk0_row67: got %h want 20", obs_byte[8'h67]);
    end
    for (int r = 0; r < 128; r++) if (r != 8'h67 && obs_byte[r] !== 8'h00) other++;
    for (int c = 0; c < 512; c++) if (obs_mask[c] !== 4'b0001) other++;
    checks++;
    if (other != 0) begin errors++; $display("FAIL blk0_other_rows: got %0d bad want 0", other); end
  endtask

  task automatic test_search_hit();
    search(28'h1234567, 0, 1);
    search(28'h1234566, 0, 1);
  endtask

  task automatic test_wildcard();
    send(2'd1, 6'd40, 28'($urandom), 28'h0000000);
    sweep(6'd40, -1);
    search(28'($urandom), 10, 1);
    search(28'h1234567, 10, 1);
  endtask

  task automatic test_invalidate();
    send(2'd2, 6'd5, 28'd0, 28'd0);
    sweep(6'd5, -1);
    search(28'h1234567, 0, 1);
    send(2'd2, 6'd40, 28'd0, 28'd0);
    sweep(6'd40, -1);
    search(28'h1234567, 0, 1);
  endtask

  task automatic test_reserved();
    int act0 = n_rd + n_wr, bad = 0;
    send(2'd3, 6'd7, 28'h5555555, 28'hFFFFFFF);
    repeat (5) begin
      @(negedge in_clk);
      if (tcam_csb !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || n_rd + n_wr != act0) begin
      errors++; $display("FAIL reserved_op: got %0d bad cycles, %0d tcam ops want 0 0", bad, n_rd + n_wr - act0);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ent;
    logic [27:0] k;
    // Same-group overwrite first: old key must miss once the rule moves.
    send(2'd1, 6'd6, 28'hABCDEF0, 28'hFFFFFFF); sweep(6'd6, -1);
    send(2'd1, 6'd6, 28'h0FEDCBA, 28'hFFFFFF0); sweep(6'd6, -1);
    search(28'hABCDEF0, 0, 1);
    search(28'h0FEDCB5, 0, 1);
    for (int it = 0; it < 16; it++) begin
      int r = $urandom_range(0, 3);
      ent = 6'($urandom_range(0, 63));
      if (r == 0) begin
        send(2'd1, ent, 28'($urandom), 28'($urandom) | 28'($urandom));
        sweep(ent, -1);
      end else if (r == 1 && mv[ent]) begin
        send(2'd2, ent, 28'd0, 28'd0);
        sweep(ent, -1);
      end else begin
        int e = $urandom_range(0, 63);
        k = mv[e] ? (mk[e] ^ (28'($urandom) & ~mc[e])) : 28'($urandom);
        search(k, $urandom_range(0, 3), 1);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    send(2'd1, 6'd9, 28'h7654321, 28'hFFFFFFF); sweep(6'd9, -1);
    search(28'h7654321, 0, 1);
    send(2'd1, 6'd12, 28'h0ABCDEF, 28'hFFFFFFF);
    sweep(6'd12, 200);
    in_rstn = 1'b0;
    #1 check_reset_outputs("reset_mid_sweep");
    for (int e = 0; e < 64; e++) mv[e] = 0;
    @(negedge in_clk);
    in_rstn = 1'b1;
    @(negedge in_clk);
    check_reset_outputs("after_mid_sweep_release");
    search(28'h7654321, 0, 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    for (int e = 0; e < 64; e++) begin mv[e] = 0; mk[e] = '0; mc[e] = '0; end
    test_reset();
    test_search_empty();
    test_write();
    test_search_hit();
    test_wildcard();
    test_invalidate();
    test_reserved();
    test_random();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
